// File: rtl/button_event_arbiter.sv
// -----------------------------------------------------------------------------
// button_event_arbiter
//
// Collects one-cycle press pulses from N debouncers and holds each one as a
// pending request. Requests are served one at a time to a single consumer over
// a valid/ready handshake, in round-robin order. A press that arrives while the
// same button is still pending sets a sticky overflow bit.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   pulse_i      [N-1:0] one-cycle press pulses, one bit per button
//   evt_valid_o  event offered to the consumer
//   evt_id_o     [IDW-1:0] index of the offered button
//   evt_ready_i  consumer accepts the offered event
//   pend_o       [N-1:0] pending-request bits
//   ovf_o        [N-1:0] sticky overflow bits
//   clr_ovf_i    clears all overflow bits on the next edge
// -----------------------------------------------------------------------------
module button_event_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic [N-1:0]   pulse_i,
   output logic           evt_valid_o,
   output logic [IDW-1:0] evt_id_o,
   input  logic           evt_ready_i,
   output logic [N-1:0]   pend_o,
   output logic [N-1:0]   ovf_o,
   input  logic           clr_ovf_i
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   state_t         r_state;
   logic           r_valid;
   logic [IDW-1:0] r_id;
   logic [IDW-1:0] r_last;
   logic [N-1:0]   r_pend;
   logic [N-1:0]   r_ovf;

   logic           w_found;
   logic [IDW-1:0] w_sel;
   logic [IDW:0]   w_cand;
   logic [N-1:0]   w_clr;
   logic [N-1:0]   w_pend_nxt;
   logic [N-1:0]   w_ovf_nxt;

   // Round-robin search: first pending bit starting at last+1, wrapping at N.
   // One extra bit of headroom keeps last+i below 2N before the wrap.
   always_comb begin
      w_found = 1'b0;
      w_sel   = {IDW{1'b0}};
      w_cand  = {(IDW+1){1'b0}};
      for (int i = 1; i <= N; i++) begin
         w_cand = {1'b0, r_last} + (IDW+1)'(i);
         if (w_cand >= (IDW+1)'(N)) begin
            w_cand = w_cand - (IDW+1)'(N);
         end else begin
            w_cand = w_cand;
         end
         if (!w_found && r_pend[w_cand[IDW-1:0]]) begin
            w_found = 1'b1;
            w_sel   = w_cand[IDW-1:0];
         end else begin
            w_found = w_found;
         end
      end
   end

   // Next pending/overflow state; a fresh pulse always wins over the clear.
   always_comb begin
      w_clr = {N{1'b0}};
      if ((r_state == ST_IDLE) && w_found) begin
         w_clr[w_sel] = 1'b1;
      end else begin
         w_clr = {N{1'b0}};
      end
      w_pend_nxt = (r_pend & ~w_clr) | pulse_i;
      // Overflow only when the bit stays pending; a new overflow beats clr_ovf_i.
      w_ovf_nxt  = (clr_ovf_i ? {N{1'b0}} : r_ovf) | (pulse_i & r_pend & ~w_clr);
   end

   // Request bookkeeping and the IDLE/OFFER handshake state machine.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_id    <= {IDW{1'b0}};
         r_last  <= IDW'(N-1);
         r_pend  <= {N{1'b0}};
         r_ovf   <= {N{1'b0}};
      end else begin
         r_pend <= w_pend_nxt;
         r_ovf  <= w_ovf_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_id    <= w_sel;
                  r_last  <= w_sel;
                  r_valid <= 1'b1;
                  r_state <= ST_OFFER;
               end else begin
                  r_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_OFFER: begin
               if (evt_ready_i) begin
                  r_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_valid <= 1'b1;
                  r_state <= ST_OFFER;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign evt_valid_o = r_valid;
   assign evt_id_o    = r_id;
   assign pend_o      = r_pend;
   assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_button_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_button_event_arbiter
//
// Directed test-plan steps followed by random pulses/ready/clear, each cycle
// compared against a per-button reference model of pending, overflow and
// round-robin service.
// -----------------------------------------------------------------------------
module tb_button_event_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   pulse;
   logic           evt_valid;
   logic [IDW-1:0] evt_id;
   logic           ready;
   logic [N-1:0]   pend;
   logic [N-1:0]   ovf;
   logic           clr;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model state
   bit       m_valid;
   int       m_id;
   int       m_last;
   bit [3:0] m_pend;
   bit [3:0] m_ovf;

   int hs_q[$];

   button_event_arbiter #(.N(N), .IDW(IDW)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .pulse_i    (pulse),
      .evt_valid_o(evt_valid),
      .evt_id_o   (evt_id),
      .evt_ready_i(ready),
      .pend_o     (pend),
      .ovf_o      (ovf),
      .clr_ovf_i  (clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_id    = 0;
      m_last  = N - 1;
      m_pend  = 4'b0000;
      m_ovf   = 4'b0000;
   endtask

   // One clock cycle: drive at negedge, advance model, compare after the edge.
   task automatic step(input logic [3:0] p, input logic rdy, input logic c);
      int       sel;
      int       b;
      bit [3:0] np;
      bit [3:0] no;
      @(negedge clk);
      pulse = p;
      ready = rdy;
      clr   = c;
      if (evt_valid && rdy) hs_q.push_back(int'(evt_id));
      sel = -1;
      if (!m_valid) begin
         for (int k = 1; k <= N; k++) begin
            b = (m_last + k) % N;
            if (sel < 0 && m_pend[b]) sel = b;
         end
      end
      for (int q = 0; q < N; q++) begin
         np[q] = (m_pend[q] && q != sel) || p[q];
         no[q] = (c ? 1'b0 : m_ovf[q]) || (p[q] && m_pend[q] && q != sel);
      end
      m_pend = np;
      m_ovf  = no;
      if (m_valid) begin
         if (rdy) m_valid = 1'b0;
      end else if (sel >= 0) begin
         m_valid = 1'b1;
         m_id    = sel;
         m_last  = sel;
      end
      @(posedge clk);
      #1;
      chk("valid", 32'(evt_valid), 32'(m_valid));
      chk("id",    32'(evt_id),    32'(m_id));
      chk("pend",  32'(pend),      32'(m_pend));
      chk("ovf",   32'(ovf),       32'(m_ovf));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      pulse = 4'hF;
      ready = 1'b0;
      clr   = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_valid", 32'(evt_valid), 32'd0);
      chk("rst_id",    32'(evt_id),    32'd0);
      chk("rst_pend",  32'(pend),      32'd0);
      chk("rst_ovf",   32'(ovf),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulse = 4'h0;
      model_reset();
   endtask

   initial begin
      rst_n = 1'b0;
      pulse = 4'h0;
      ready = 1'b0;
      clr   = 1'b0;
      model_reset();

      // Reset, then a single press of button 2 with ready held high
      do_reset();
      step(4'b0100, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      chk("first_valid", 32'(evt_valid), 32'd1);
      chk("first_id",    32'(evt_id),    32'd2);
      chk("first_pend",  32'(pend),      32'd0);
      step(4'b0000, 1'b1, 1'b0);
      chk("first_drop",  32'(evt_valid), 32'd0);

      // Round-robin: burst 0,1,3 then burst 0,3 after the pointer wraps
      do_reset();
      hs_q.delete();
      step(4'b1011, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(4'b0000, 1'b1, 1'b0);
      step(4'b1001, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(4'b0000, 1'b1, 1'b0);
      chk("rr_count", 32'(hs_q.size()), 32'd5);
      if (hs_q.size() == 5) begin
         chk("rr_0", 32'(hs_q[0]), 32'd0);
         chk("rr_1", 32'(hs_q[1]), 32'd1);
         chk("rr_2", 32'(hs_q[2]), 32'd3);
         chk("rr_3", 32'(hs_q[3]), 32'd0);
         chk("rr_4", 32'(hs_q[4]), 32'd3);
      end

      // Stall: id 1 offered for 10 cycles while button 2 is pressed
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step((i == 3) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
         chk("stall_id",    32'(evt_id),    32'd1);
         chk("stall_valid", 32'(evt_valid), 32'd1);
      end
      chk("stall_pend", 32'(pend), 32'h4);
      step(4'b0000, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      chk("stall_next_id", 32'(evt_id), 32'd2);
      step(4'b0000, 1'b1, 1'b0);

      // Overflow on bit 3 while id 0 is stalled, clear, then clear-vs-set
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0);
      step(4'b1000, 1'b0, 1'b0);
      step(4'b1000, 1'b0, 1'b0);
      chk("ovf_set", 32'(ovf), 32'h8);
      step(4'b0000, 1'b0, 1'b1);
      chk("ovf_clr", 32'(ovf), 32'h0);
      step(4'b1000, 1'b0, 1'b1);
      chk("ovf_set_wins", 32'(ovf), 32'h8);
      for (int i = 0; i < 6; i++) step(4'b0000, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b1);

      // Set-wins: press bit 0 in the cycle IDLE selects bit 0
      do_reset();
      step(4'b0001, 1'b1, 1'b0);
      step(4'b0001, 1'b1, 1'b0);
      chk("sw_pend", 32'(pend), 32'h1);
      chk("sw_ovf",  32'(ovf),  32'h0);
      step(4'b0000, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      chk("sw_again_valid", 32'(evt_valid), 32'd1);
      chk("sw_again_id",    32'(evt_id),    32'd0);
      step(4'b0000, 1'b1, 1'b0);

      // Asynchronous reset while an event is offered
      step(4'b0100, 1'b0, 1'b0);
      step(4'b1010, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0);
      chk("ar_pre_valid", 32'(evt_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(evt_valid), 32'd0);
      chk("ar_pend",  32'(pend),      32'd0);
      chk("ar_ovf",   32'(ovf),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulse = 4'h0;
      model_reset();

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(4'($urandom & $urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
